// File: rtl/nw_pkg.sv
// -----------------------------------------------------------------------------
// nw_pkg
// Shared definitions for the Needleman-Wunsch datapath: default scoring
// constants (so the fill stage and the traceback use identical values), the
// traceback FSM state encoding, RAM address selectors and direction codes.
// -----------------------------------------------------------------------------
package nw_pkg;

    localparam int NW_N        = 5;
    localparam int NW_MATCH    = 1;
    localparam int NW_MISMATCH = -1;
    localparam int NW_GAP      = -2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CUR  = 3'd1,
        ST_WT_CUR  = 3'd2,
        ST_CHECK   = 3'd3,
        ST_WT_DIAG = 3'd4,
        ST_WT_UP   = 3'd5,
        ST_EMIT    = 3'd6,
        ST_DONE    = 3'd7
    } tb_state_t;

    // Which neighbour of the registered (i,j) the read address points at.
    typedef enum logic [1:0] {
        SEL_CUR  = 2'd0,
        SEL_DIAG = 2'd1,
        SEL_UP   = 2'd2
    } addr_sel_t;

    localparam logic [1:0] DIR_DIAG_M = 2'b00;  // diagonal, symbols equal
    localparam logic [1:0] DIR_DIAG_X = 2'b01;  // diagonal, substitution
    localparam logic [1:0] DIR_UP     = 2'b10;  // gap in B
    localparam logic [1:0] DIR_LEFT   = 2'b11;  // gap in A

    // Both diagonal codes share a clear MSB.
    function automatic logic is_diag(input logic [1:0] dir);
        return ~dir[1];
    endfunction

endpackage

// File: rtl/nw_tb_addr_gen.sv
// -----------------------------------------------------------------------------
// nw_tb_addr_gen
// Combinational row-major address generator for the traceback read port.
//   i, j : current cell coordinates
//   sel  : SEL_CUR -> (i,j), SEL_DIAG -> (i-1,j-1), SEL_UP -> (i-1,j)
//   addr : i' * (N+1) + j'
// Out-of-range results (e.g. SEL_UP with i=0) are never used with a read enable.
// -----------------------------------------------------------------------------
module nw_tb_addr_gen
    import nw_pkg::*;
#(
    parameter int N  = NW_N,
    parameter int IW = $clog2(N + 1),
    parameter int AW = $clog2(((N + 1) * (N + 1)) - 1) + 1
) (
    input  logic [IW-1:0] i,
    input  logic [IW-1:0] j,
    input  addr_sel_t     sel,
    output logic [AW-1:0] addr
);

    int row;
    int col;

    // NOTE: every variable written in a combinational block gets a value on
    // every path (defaults first); otherwise synthesis infers a latch.
    always_comb begin
        row = int'(i);
        col = int'(j);
        if (sel != SEL_CUR)  row = row - 1;
        if (sel == SEL_DIAG) col = col - 1;
        addr = AW'(row * (N + 1) + col);
    end

endmodule

// File: rtl/nw_traceback.sv
// -----------------------------------------------------------------------------
// nw_traceback
// Walks the filled NW score matrix from (N,N) back to (0,0) through the
// Scores_RAM read port, recomputing each predecessor from neighbour scores.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a traceback (sampled only in IDLE)
//   seq_a, seq_b      : 2-bit symbols, symbol k at [2k+:2]
//   en_dout/addr_dout : RAM read enable / address (data valid next cycle)
//   dout              : RAM read data, 9-bit signed
//   busy              : traceback in progress
//   out_valid         : one pulse per step with out_dir, out_i, out_j
//   done              : one pulse after the final step
// Tie priority is diag > up > left; the left cell is inferred, never read.
// -----------------------------------------------------------------------------
module nw_traceback
    import nw_pkg::*;
#(
    parameter int N           = NW_N,
    parameter int MATCH       = NW_MATCH,
    parameter int MISMATCH    = NW_MISMATCH,
    parameter int GAP         = NW_GAP,
    parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2*N-1:0]           seq_a,
    input  logic [2*N-1:0]           seq_b,
    output logic                     en_dout,
    output logic [addr_lenght:0]     addr_dout,
    input  logic signed [8:0]        dout,
    output logic                     busy,
    output logic                     out_valid,
    output logic [1:0]               out_dir,
    output logic [$clog2(N+1)-1:0]   out_i,
    output logic [$clog2(N+1)-1:0]   out_j,
    output logic                     done
);

    localparam int IW = $clog2(N + 1);
    localparam int AW = addr_lenght + 1;
    localparam logic [IW-1:0]    N_IDX      = IW'(N);
    localparam logic signed [9:0] MATCH_W    = 10'(MATCH);
    localparam logic signed [9:0] MISMATCH_W = 10'(MISMATCH);
    localparam logic signed [9:0] GAP_W      = 10'(GAP);

    tb_state_t         state, next_state;
    addr_sel_t         addr_sel;
    logic [IW-1:0]     i_r, j_r;
    logic signed [8:0] cur;
    logic [1:0]        dir_r;
    logic [AW-1:0]     gen_addr, addr_hold;
    logic [1:0]        sym_a, sym_b;
    logic              is_match, diag_hit, up_hit, at_row0, at_col0;
    logic signed [9:0] dout_w, cur_w, s_w, step_w;

    nw_tb_addr_gen #(.N(N), .IW(IW), .AW(AW)) u_addr_gen (
        .i    (i_r),
        .j    (j_r),
        .sel  (addr_sel),
        .addr (gen_addr)
    );

    // Symbols a[i-1] and b[j-1] for the current cell.
    always_comb begin
        sym_a = '0;
        sym_b = '0;
        for (int k = 0; k < N; k++) begin
            if (i_r == IW'(k + 1)) sym_a = seq_a[2*k +: 2];
            if (j_r == IW'(k + 1)) sym_b = seq_b[2*k +: 2];
        end
    end

    // All score arithmetic is widened to 10 bits so dout+s cannot wrap.
    assign is_match = (sym_a == sym_b);
    assign s_w      = is_match ? MATCH_W : MISMATCH_W;
    assign dout_w   = 10'(dout);
    assign cur_w    = 10'(cur);
    assign diag_hit = (dout_w + s_w) == cur_w;
    assign up_hit   = (dout_w + GAP_W) == cur_w;
    assign at_row0  = (i_r == '0);
    assign at_col0  = (j_r == '0);
    assign step_w   = is_diag(dir_r) ? s_w : GAP_W;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start) next_state = ST_RD_CUR;
            ST_RD_CUR:  next_state = ST_WT_CUR;
            ST_WT_CUR:  next_state = ST_CHECK;
            ST_CHECK: begin
                if (at_row0 && at_col0)      next_state = ST_DONE;
                else if (at_row0 || at_col0) next_state = ST_EMIT;
                else                         next_state = ST_WT_DIAG;
            end
            ST_WT_DIAG: next_state = diag_hit ? ST_EMIT : ST_WT_UP;
            ST_WT_UP:   next_state = ST_EMIT;
            ST_EMIT:    next_state = ST_CHECK;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Read issue: the address is combinational from the registered (i,j) so
    // data arrives in the following state.
    always_comb begin
        en_dout  = 1'b0;
        addr_sel = SEL_CUR;
        case (state)
            ST_RD_CUR: en_dout = 1'b1;
            ST_CHECK: begin
                if (!at_row0 && !at_col0) begin
                    en_dout  = 1'b1;
                    addr_sel = SEL_DIAG;
                end
            end
            ST_WT_DIAG: begin
                if (!diag_hit) begin
                    en_dout  = 1'b1;
                    addr_sel = SEL_UP;
                end
            end
            default: ;
        endcase
    end

    // The address bus keeps its last driven value while no read is issued.
    assign addr_dout = en_dout ? gen_addr : addr_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_r       <= '0;
            j_r       <= '0;
            cur       <= '0;
            dir_r     <= '0;
            addr_hold <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_dir   <= '0;
            out_i     <= '0;
            out_j     <= '0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            addr_hold <= addr_dout;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i_r  <= N_IDX;
                        j_r  <= N_IDX;
                        busy <= 1'b1;
                    end
                end
                ST_WT_CUR: cur <= dout;
                ST_CHECK:  dir_r <= at_row0 ? DIR_LEFT : DIR_UP;
                ST_WT_DIAG: begin
                    if (diag_hit) dir_r <= is_match ? DIR_DIAG_M : DIR_DIAG_X;
                end
                ST_WT_UP:  dir_r <= up_hit ? DIR_UP : DIR_LEFT;
                ST_EMIT: begin
                    out_valid <= 1'b1;
                    out_dir   <= dir_r;
                    out_i     <= i_r;
                    out_j     <= j_r;
                    // Predecessor score: undo the move that produced cur.
                    cur       <= 9'(cur_w - step_w);
                    if (dir_r != DIR_LEFT) i_r <= i_r - IW'(1);
                    if (dir_r != DIR_UP)   j_r <= j_r - IW'(1);
                end
                ST_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_traceback.sv
// -----------------------------------------------------------------------------
// tb_nw_traceback
// Self-checking bench for nw_traceback (N=5). Holds a Scores_RAM model with a
// one-cycle read latency, fills it with a standard NW matrix (or a hand-built
// one) and compares every step, read address and timing against a reference
// traceback computed from the scoring rules.
// -----------------------------------------------------------------------------
module tb_nw_traceback;
    import nw_pkg::*;

    localparam int N     = 5;
    localparam int D     = N + 1;
    localparam int CELLS = D * D;
    localparam int AL    = $clog2(CELLS - 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2*N-1:0]    seq_a, seq_b;
    logic              en_dout;
    logic [AL:0]       addr_dout;
    logic signed [8:0] dout;
    logic              busy, out_valid, done;
    logic [1:0]        out_dir;
    logic [2:0]        out_i, out_j;

    logic signed [8:0] ram [0:CELLS-1];

    int checks = 0;
    int errors = 0;

    // Expected and observed traces.
    int exp_dir[$], exp_i[$], exp_j[$], exp_cyc[$], exp_rd[$];
    int exp_done;
    int got_dir[$], got_i[$], got_j[$], got_cyc[$], got_rd[$];
    int got_done_cyc;

    always #5 clk = ~clk;

    // Scores_RAM read port: data valid the cycle after the enable.
    always @(posedge clk) if (en_dout) dout <= ram[addr_dout];

    nw_traceback #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seq_a     (seq_a),
        .seq_b     (seq_b),
        .en_dout   (en_dout),
        .addr_dout (addr_dout),
        .dout      (dout),
        .busy      (busy),
        .out_valid (out_valid),
        .out_dir   (out_dir),
        .out_i     (out_i),
        .out_j     (out_j),
        .done      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sym(input logic [2*N-1:0] s, input int k);
        return int'(s[2*k +: 2]);
    endfunction

    // Standard NW fill of the RAM from seq_a / seq_b.
    task automatic fill_standard();
        int h [0:N][0:N];
        int sc, best;
        for (int i = 0; i <= N; i++) begin
            for (int j = 0; j <= N; j++) begin
                if (i == 0)      h[i][j] = j * NW_GAP;
                else if (j == 0) h[i][j] = i * NW_GAP;
                else begin
                    sc   = (sym(seq_a, i-1) == sym(seq_b, j-1)) ? NW_MATCH : NW_MISMATCH;
                    best = h[i-1][j-1] + sc;
                    if (h[i-1][j] + NW_GAP > best) best = h[i-1][j] + NW_GAP;
                    if (h[i][j-1] + NW_GAP > best) best = h[i][j-1] + NW_GAP;
                    h[i][j] = best;
                end
                ram[i*D + j] = 9'(h[i][j]);
            end
        end
    endtask

    // Reference traceback over whatever matrix is in the RAM. Cycle numbers
    // count clocks after the edge that accepts start: the first decision
    // point is cycle 3; a step's pulse lands len cycles after its decision
    // point (diag 3, diag-miss 4, boundary 2); done follows the (0,0)
    // decision by 2 cycles.
    task automatic build_model();
        int i, j, c, cur, sc, dv, ln;
        exp_dir.delete(); exp_i.delete(); exp_j.delete();
        exp_cyc.delete(); exp_rd.delete();
        i = N; j = N; c = 3; sc = 0;
        cur = int'(ram[N*D + N]);
        exp_rd.push_back(N*D + N);
        while (i != 0 || j != 0) begin
            if (i == 0) begin
                dv = 3; ln = 2;
            end else if (j == 0) begin
                dv = 2; ln = 2;
            end else begin
                sc = (sym(seq_a, i-1) == sym(seq_b, j-1)) ? NW_MATCH : NW_MISMATCH;
                exp_rd.push_back((i-1)*D + (j-1));
                if (int'(ram[(i-1)*D + (j-1)]) + sc == cur) begin
                    dv = (sc == NW_MATCH) ? 0 : 1;
                    ln = 3;
                end else begin
                    exp_rd.push_back((i-1)*D + j);
                    dv = (int'(ram[(i-1)*D + j]) + NW_GAP == cur) ? 2 : 3;
                    ln = 4;
                end
            end
            c += ln;
            exp_dir.push_back(dv); exp_i.push_back(i); exp_j.push_back(j);
            exp_cyc.push_back(c);
            if (dv < 2)       begin cur -= sc;     i--; j--; end
            else if (dv == 2) begin cur -= NW_GAP; i--;      end
            else              begin cur -= NW_GAP; j--;      end
        end
        exp_done = c + 2;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " en_dout"},   int'(en_dout),   0);
        check({name, " addr_dout"}, int'(addr_dout), 0);
        check({name, " busy"},      int'(busy),      0);
        check({name, " out_valid"}, int'(out_valid), 0);
        check({name, " out_dir"},   int'(out_dir),   0);
        check({name, " out_i"},     int'(out_i),     0);
        check({name, " out_j"},     int'(out_j),     0);
        check({name, " done"},      int'(done),      0);
    endtask

    // Starts a traceback at the current negedge and records its outputs.
    // hold: keep start high until done is seen. rst_after > 0: pulse rst once
    // that many steps have been emitted and check the block went idle.
    task automatic run_trace(input string name, input bit hold, input int rst_after);
        int  done_cnt, busy_bad, back2back;
        bit  prev_ov;
        got_dir.delete(); got_i.delete(); got_j.delete();
        got_cyc.delete(); got_rd.delete();
        got_done_cyc = -1;
        done_cnt = 0; busy_bad = 0; back2back = 0; prev_ov = 1'b0;
        build_model();
        start = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (en_dout) got_rd.push_back(int'(addr_dout));
            if (out_valid) begin
                if (prev_ov) back2back++;
                got_dir.push_back(int'(out_dir));
                got_i.push_back(int'(out_i));
                got_j.push_back(int'(out_j));
                got_cyc.push_back(cyc);
            end
            prev_ov = out_valid;
            if (busy !== (cyc < exp_done)) busy_bad++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    got_done_cyc = cyc;
                    start = 1'b0;
                end
            end
            if (rst_after > 0 && got_dir.size() == rst_after) begin
                rst = 1'b1;
                @(negedge clk);
                check_outputs_zero({name, " after rst"});
                check({name, " no partial done"}, done_cnt, 0);
                check({name, " busy before rst"}, busy_bad, 0);
                rst = 1'b0;
                return;
            end
            if (done_cnt > 0 && cyc >= got_done_cyc + 8) break;
        end
        check({name, " done count"}, done_cnt, 1);
        check({name, " done cycle"}, got_done_cyc, exp_done);
        check({name, " steps"}, got_dir.size(), exp_dir.size());
        check({name, " step range"},
              int'(got_dir.size() >= N && got_dir.size() <= 2*N), 1);
        for (int k = 0; k < exp_dir.size() && k < got_dir.size(); k++) begin
            check($sformatf("%s dir[%0d]", name, k), got_dir[k], exp_dir[k]);
            check($sformatf("%s i[%0d]",   name, k), got_i[k],   exp_i[k]);
            check($sformatf("%s j[%0d]",   name, k), got_j[k],   exp_j[k]);
            check($sformatf("%s cyc[%0d]", name, k), got_cyc[k], exp_cyc[k]);
        end
        check({name, " reads"}, got_rd.size(), exp_rd.size());
        for (int k = 0; k < exp_rd.size() && k < got_rd.size(); k++)
            check($sformatf("%s rd[%0d]", name, k), got_rd[k], exp_rd[k]);
        check({name, " busy profile"}, busy_bad, 0);
        check({name, " back-to-back valid"}, back2back, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; seq_a = '0; seq_b = '0;
        for (int a = 0; a < CELLS; a++) ram[a] = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Identical sequences ACGTA / ACGTA: five diagonal matches.
        seq_a = 10'b00_11_10_01_00;
        seq_b = 10'b00_11_10_01_00;
        fill_standard();
        run_trace("ident", 1'b0, 0);
        check("ident count", got_dir.size(), 5);
        for (int s = 0; s < 5 && s < got_dir.size(); s++) begin
            check($sformatf("ident const dir[%0d]", s), got_dir[s], 0);
            check($sformatf("ident const i[%0d]", s),   got_i[s],   5 - s);
        end
        if (got_cyc.size() > 0) check("ident first valid cycle", got_cyc[0], 6);
        check("ident done cycle const", got_done_cyc, 20);

        // ACGTA / ACTTA: substitution at (3,3).
        seq_b = 10'b00_11_11_01_00;
        fill_standard();
        run_trace("subst", 1'b0, 0);
        check("subst count", got_dir.size(), 5);
        for (int s = 0; s < 5 && s < got_dir.size(); s++)
            check($sformatf("subst const dir[%0d]", s), got_dir[s], (s == 2) ? 1 : 0);

        // Hand-built matrix: diag, diag, diag, up, up, then along row 0.
        seq_a = '0; seq_b = '0;
        for (int a = 0; a < CELLS; a++) ram[a] = -9'sd200;
        ram[0]  = 9'sd0;   ram[1]  = -9'sd2; ram[2]  = -9'sd4;
        ram[8]  = -9'sd6;  ram[14] = -9'sd8; ram[21] = -9'sd7;
        ram[28] = -9'sd6;  ram[35] = -9'sd5;
        run_trace("row0", 1'b0, 0);
        check("row0 count", got_dir.size(), 7);
        if (got_dir.size() == 7) begin
            check("row0 dir[5]", got_dir[5], 3);
            check("row0 j[5]",   got_j[5],   2);
            check("row0 dir[6]", got_dir[6], 3);
            check("row0 j[6]",   got_j[6],   1);
            check("row0 i[6]",   got_i[6],   0);
        end
        check("row0 reads const", got_rd.size(), 8);

        // Tie at (5,5): up cell made consistent too; diag must win unread-up.
        seq_a = 10'b00_11_10_01_00;
        seq_b = 10'b00_11_10_01_00;
        fill_standard();
        ram[4*D + 5] = 9'sd7;
        run_trace("tie", 1'b0, 0);
        if (got_dir.size() > 0) check("tie dir[0]", got_dir[0], 0);
        k = 0;
        foreach (got_rd[r]) if (got_rd[r] == 4*D + 5) k++;
        check("tie up addr issued", k, 0);

        // Reset after the second step, then a clean rerun.
        fill_standard();
        run_trace("rst", 1'b0, 2);
        run_trace("after rst", 1'b0, 0);
        if (got_rd.size() > 0) check("after rst first addr", got_rd[0], 35);

        // start held high for the whole run.
        run_trace("hold", 1'b1, 0);

        // Randomized sequences, B derived from A with a few substitutions.
        for (int t = 0; t < 30; t++) begin
            seq_a = 10'($urandom);
            if ($urandom_range(0, 3) == 0) seq_b = 10'($urandom);
            else begin
                seq_b = seq_a;
                repeat ($urandom_range(0, 3)) begin
                    k = $urandom_range(0, N - 1);
                    seq_b[2*k +: 2] = 2'($urandom);
                end
            end
            fill_standard();
            run_trace($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nw_traceback.md
# nw_traceback

Read-side consumer of `Scores_RAM` in the Needleman-Wunsch datapath. After the score-fill stage has written the (N+1)x(N+1) matrix, this block walks the matrix from cell (N,N) back to (0,0) through the RAM read port. It recomputes each step's predecessor from neighbour scores and emits one alignment direction per step, last step first.

## Interface
- `N`, 5, sequence length; matrix is (N+1)x(N+1), row-major, addr = i*(N+1)+j.
- `MATCH`, 1, signed score for equal symbols.
- `MISMATCH`, -1, signed score for unequal symbols.
- `GAP`, -2, signed gap penalty.
- `addr_lenght`, $clog2(((N+1)*(N+1))-1), address MSB index; addresses are [addr_lenght:0].

Ports:
- `clk` in 1: single clock; everything on posedge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: begin traceback; sampled only in IDLE.
- `seq_a` in 2N: row sequence, symbol k at [2k+:2], used for i = k+1.
- `seq_b` in 2N: column sequence, symbol k at [2k+:2], used for j = k+1.
- `en_dout` out 1: RAM read enable, to `Scores_RAM.en_dout`.
- `addr_dout` out addr_lenght+1: RAM read address.
- `dout` in 9 signed: RAM read data, valid the cycle after `en_dout`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `out_valid` out 1: one-cycle pulse per traceback step.
- `out_dir` out 2: 00 diag match, 01 diag mismatch, 10 up (gap in B), 11 left (gap in A).
- `out_i`, `out_j` out $clog2(N+1): cell the step leaves, before the move.
- `done` out 1: one-cycle pulse after the final step.

## Operation
- States: IDLE, RD_CUR, WT_CUR, CHECK, WT_DIAG, WT_UP, EMIT, DONE.
- IDLE: when `start`=1, load i=N, j=N and go to RD_CUR.
- RD_CUR: `en_dout`=1, addr=(N,N). Go to WT_CUR.
- WT_CUR: latch `dout` into `cur` (9-bit signed). Go to CHECK.
- CHECK:
  - i=0 and j=0: go to DONE.
  - i=0 only: dir=11, go to EMIT.
  - j=0 only: dir=10, go to EMIT.
  - Otherwise: issue read of (i-1,j-1) and go to WT_DIAG.
- WT_DIAG: s = MATCH if a[i-1]==b[j-1], else MISMATCH.
  - If dout+s == cur: dir = 00 or 01, go to EMIT.
  - Else: issue read of (i-1,j) and go to WT_UP.
- WT_UP:
  - If dout+GAP == cur: dir=10.
  - Else: dir=11; the left cell is not read.
  - Go to EMIT.
- Tie priority: diag > up > left.
- EMIT: register `out_valid`=1 with dir and the current (i,j).
  - Update cur ← cur−s for diag, cur ← cur−GAP for up/left.
  - Decrement i, j, or both.
  - Return to CHECK.
- DONE: pulse `done`, drop `busy`, return to IDLE.
- Arithmetic: sums and compares are computed in 10-bit signed to prevent overflow; `cur` is stored 9-bit.
- `start` while busy: ignored.
- `en_dout`=0 in every state that does not issue a read; `addr_dout` holds its last value.
- The block never writes the RAM.

## Timing
- Reset values: `en_dout`, `addr_dout`, `busy`, `out_valid`, `out_dir`, `out_i`, `out_j`, `done` all 0; state IDLE.
- `rst` mid-traceback returns the block to IDLE on the next edge with all outputs 0. No partial `done` is issued.
- RAM latency is one cycle: address issued in state X (combinational from registered i,j); data sampled in the following state.
- `out_valid` is asserted one cycle after the EMIT entry decision. It is never high for two consecutive cycles.
- Per-step cost:
  - Diag step: CHECK + WT_DIAG + EMIT = 3 cycles.
  - Up/left step after a diag miss: 4 cycles.
  - Boundary step: 2 cycles.
- Startup: `start` → first possible `out_valid` is 6 cycles later (RD_CUR, WT_CUR, CHECK, WT_DIAG, EMIT, output register).
- `done` occurs exactly one cycle after the DONE state is entered from CHECK at (0,0).
- Step count is between N and 2N inclusive.

## Structure
- Shared package `nw_pkg` holds:
  - state enum encoding;
  - direction codes DIR_DIAG_M/DIR_DIAG_X/DIR_UP/DIR_LEFT;
  - default MATCH/MISMATCH/GAP constants, so the fill stage uses identical values.
- Sub-module `nw_tb_addr_gen`: combinational (i,j,sel) → i'*(N+1)+j' for sel ∈ {cur, diag, up}.
- The FSM and datapath are in `nw_traceback`.

## Test plan
The bench preloads `Scores_RAM` (N=5) via its write port, then starts this block.
- Identical sequences, seq_a=seq_b=ACGTA, standard NW matrix → 5 pulses, all dir 00, coords (5,5),(4,4)…(1,1); `done` 1 cycle after the last DONE entry; `busy` low after.
- seq_b=ACTTA (one substitution at j=3) → 5 diag pulses; the pulse at (3,3) has dir 01, the rest 00.
- Matrix forcing the path onto row 0 at (0,2) → final two pulses dir 11 at (0,2),(0,1), with no RAM reads (`en_dout`=0) during them.
- Tie cell where diag and up are both consistent → dir 00/01 chosen; the up address is never issued at that step.
- `rst` pulse after the 2nd `out_valid` → next cycle all outputs 0, IDLE. A fresh `start` re-reads addr 35 and repeats the full sequence.
- `start` held high throughout a traceback → exactly one traceback and one `done`; `busy` never drops mid-run.
